// File: rtl/uart_transceiver_if.sv
// Byte-level client interface of uart_transceiver: TX handshake and RX strobes.
// The client uses the master modport; the UART uses the slave modport.
interface uart_transceiver_if;
  logic       transfer;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;

  modport master (
    output transfer, tx_data,
    input  tx_ready, rx_valid, rx_data, rx_error
  );

  modport slave (
    input  transfer, tx_data,
    output tx_ready, rx_valid, rx_data, rx_error
  );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART with independent TX and RX FSMs on one clock.
// Define UART_ECHO_EN to loop received bytes back into the transmitter.
module uart_transceiver #(
  parameter int SYSTEM_CLK_MHZ = 50,
  parameter int BAUDRATE       = 3_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_transceiver_if.slave    bus,
  output logic                 tx_out,
  input  logic                 rx_in
);
  localparam int CLKS_PER_BIT = (SYSTEM_CLK_MHZ * 1_000_000 + BAUDRATE / 2) / BAUDRATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t        tx_state, tx_state_next;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_next;
  logic [2:0]       tx_bit, tx_bit_next;
  logic [7:0]       tx_shift, tx_shift_next;
  logic             tx_out_next;
  logic             tx_load;
  logic [7:0]       tx_load_data;

  rx_state_t        rx_state, rx_state_next;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_next;
  logic [2:0]       rx_bit, rx_bit_next;
  logic [7:0]       rx_shift, rx_shift_next;
  logic [7:0]       rx_data_q, rx_data_next;
  logic             rx_valid_q, rx_valid_next;
  logic             rx_error_q, rx_error_next;
  logic             rx_meta, rx_sync, rx_prev;

  assign bus.tx_ready = (tx_state == TX_IDLE);
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_error = rx_error_q;
  assign bus.rx_data  = rx_data_q;

  // A frame may also start on the last stop-bit edge so held transfers run back-to-back.
  always_comb begin
    tx_load      = 1'b0;
    tx_load_data = bus.tx_data;
    if (bus.transfer && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == BIT_LAST)))
      tx_load = 1'b1;
`ifdef UART_ECHO_EN
    if (tx_state == TX_IDLE && rx_valid_q) begin
      tx_load      = 1'b1;
      tx_load_data = rx_data_q;
    end
`endif
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_cnt_next   = tx_cnt + 1'b1;
    tx_bit_next   = tx_bit;
    tx_shift_next = tx_shift;
    tx_out_next   = tx_out;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_next = '0;
        tx_out_next = 1'b1;
      end
      TX_START: if (tx_cnt == BIT_LAST) begin
        tx_cnt_next   = '0;
        tx_out_next   = tx_shift[0];
        tx_shift_next = {1'b0, tx_shift[7:1]};
        tx_bit_next   = 3'd0;
        tx_state_next = TX_DATA;
      end
      TX_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_next = '0;
        if (tx_bit == 3'd7) begin
          tx_out_next   = 1'b1;
          tx_state_next = TX_STOP;
        end else begin
          tx_out_next   = tx_shift[0];
          tx_shift_next = {1'b0, tx_shift[7:1]};
          tx_bit_next   = tx_bit + 3'd1;
        end
      end
      TX_STOP: if (tx_cnt == BIT_LAST) begin
        tx_cnt_next   = '0;
        tx_state_next = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_state_next = TX_START;
      tx_cnt_next   = '0;
      tx_shift_next = tx_load_data;
      tx_out_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      tx_out   <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      tx_cnt   <= tx_cnt_next;
      tx_bit   <= tx_bit_next;
      tx_shift <= tx_shift_next;
      tx_out   <= tx_out_next;
    end
  end

  // Receiver samples the synchronised line at mid-bit, counting from the detected falling edge.
  always_comb begin
    rx_state_next = rx_state;
    rx_cnt_next   = rx_cnt + 1'b1;
    rx_bit_next   = rx_bit;
    rx_shift_next = rx_shift;
    rx_data_next  = rx_data_q;
    rx_valid_next = 1'b0;
    rx_error_next = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_next = '0;
        if (rx_prev && !rx_sync) rx_state_next = RX_START;
      end
      RX_START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_next   = '0;
        rx_bit_next   = 3'd0;
        rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_next   = '0;
        rx_shift_next = {rx_sync, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_next = RX_STOP;
        else                rx_bit_next   = rx_bit + 3'd1;
      end
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_next   = '0;
        rx_state_next = RX_IDLE;
        if (rx_sync) begin
          rx_data_next  = rx_shift;
          rx_valid_next = 1'b1;
        end else begin
          rx_error_next = 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= 3'd0;
      rx_shift   <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      rx_meta    <= rx_in;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      rx_state   <= rx_state_next;
      rx_cnt     <= rx_cnt_next;
      rx_bit     <= rx_bit_next;
      rx_shift   <= rx_shift_next;
      rx_data_q  <= rx_data_next;
      rx_valid_q <= rx_valid_next;
      rx_error_q <= rx_error_next;
    end
  end
endmodule

// File: tb/tb_uart_transceiver.sv
// Directed self-checking bench for uart_transceiver at default 17 clocks per bit.
// Echo checks are compiled in when UART_ECHO_EN is defined.
module tb_uart_transceiver;
  logic clk = 1'b0;
  logic reset;
  logic tx_out;
  logic rx_in;
  int   compared = 0;
  int   mismatched = 0;

  int   valid_count;
  int   err_count;
  int   valid_at;
  int   err_at;
  logic [7:0] captured;
  logic txhist [0:511];

  uart_transceiver_if bus ();

  uart_transceiver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx_out(tx_out),
    .rx_in (rx_in)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic tr, input logic [7:0] data);
    bus.transfer = tr;
    bus.tx_data  = data;
  endtask

  // Samples one whole TX frame starting with the cycle after the accepting edge.
  task automatic checkTxFrame(input logic [7:0] data, input bit poke, input logic next_tr,
                              input logic [7:0] next_data, input string tag);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int k = 0; k < 170; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_tx_out_bit%0d", tag, k / 17), 32'(tx_out), 32'(frame[k / 17]));
      checkOutput($sformatf("%s_ready_c%0d", tag, k), 32'(bus.tx_ready), 32'd0);
      if (k == 0) applyStimulus(next_tr, next_data);
      if (poke && k == 60) bus.transfer = 1'b1;
      if (poke && k == 61) bus.transfer = 1'b0;
    end
  endtask

  // Drives one RX frame (optionally starting a TX byte alongside) and logs strobes and tx_out.
  task automatic runRx(input logic [7:0] data, input logic stop, input int extra,
                       input bit do_tx, input logic [7:0] tx_byte);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    valid_count = 0; err_count = 0; valid_at = -1; err_at = -1; captured = 8'h00;
    for (int i = 0; i < 170 + extra; i++) begin
      @(negedge clk);
      txhist[i] = tx_out;
      if (bus.rx_valid) begin valid_count++; valid_at = i; captured = bus.rx_data; end
      if (bus.rx_error) begin err_count++; err_at = i; end
      rx_in = (i < 170) ? frame[i / 17] : 1'b1;
      if (do_tx && i == 0) applyStimulus(1'b1, tx_byte);
      if (do_tx && i == 1) bus.transfer = 1'b0;
    end
  endtask

  initial begin
    int errs;
    logic [9:0] fr;
    reset = 1'b1;
    rx_in = 1'b1;
    applyStimulus(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("reset_tx_out", 32'(tx_out), 32'd1);
    checkOutput("reset_tx_ready", 32'(bus.tx_ready), 32'd1);
    checkOutput("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    checkOutput("reset_rx_error", 32'(bus.rx_error), 32'd0);
    checkOutput("reset_rx_data", 32'(bus.rx_data), 32'h00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_tx_out", 32'(tx_out), 32'd1);
    checkOutput("idle_tx_ready", 32'(bus.tx_ready), 32'd1);

    $display("[TB] single TX frame 0xA5");
    applyStimulus(1'b1, 8'hA5);
    checkTxFrame(8'hA5, 1'b1, 1'b0, 8'hFF, "tx_a5");
    @(negedge clk);
    checkOutput("tx_a5_ready_after", 32'(bus.tx_ready), 32'd1);
    checkOutput("tx_a5_idle_line", 32'(tx_out), 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("tx_busy_poke_ignored_line", 32'(tx_out), 32'd1);
    checkOutput("tx_busy_poke_ignored_ready", 32'(bus.tx_ready), 32'd1);

    $display("[TB] back-to-back TX 0x01 then 0x02");
    applyStimulus(1'b1, 8'h01);
    checkTxFrame(8'h01, 1'b0, 1'b1, 8'h02, "b2b_1");
    checkTxFrame(8'h02, 1'b0, 1'b0, 8'h02, "b2b_2");
    @(negedge clk);
    checkOutput("b2b_ready_after", 32'(bus.tx_ready), 32'd1);
    checkOutput("b2b_idle_line", 32'(tx_out), 32'd1);

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(1'b1, 8'h00);
    @(negedge clk);
    bus.transfer = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midreset_before_line", 32'(tx_out), 32'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_line_high", 32'(tx_out), 32'd1);
    checkOutput("midreset_ready", 32'(bus.tx_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] RX 0x3C");
    runRx(8'h3C, 1'b1, 30, 1'b0, 8'h00);
    checkOutput("rx_3c_valid_count", 32'(valid_count), 32'd1);
    checkOutput("rx_3c_error_count", 32'(err_count), 32'd0);
    checkOutput("rx_3c_data", 32'(captured), 32'h3C);
    checkOutput("rx_3c_latency_ok", 32'(valid_at >= 153 && valid_at <= 172), 32'd1);
    checkOutput("rx_3c_data_held", 32'(bus.rx_data), 32'h3C);
`ifndef UART_ECHO_EN
    errs = 0;
    for (int i = 0; i < 200; i++) if (txhist[i] !== 1'b1) errs++;
    checkOutput("rx_3c_no_echo", 32'(errs), 32'd0);
`endif
    repeat (200) @(negedge clk);

    $display("[TB] RX framing error 0x55");
    runRx(8'h55, 1'b0, 30, 1'b0, 8'h00);
    checkOutput("ferr_error_count", 32'(err_count), 32'd1);
    checkOutput("ferr_valid_count", 32'(valid_count), 32'd0);
    checkOutput("ferr_data_kept", 32'(bus.rx_data), 32'h3C);

    $display("[TB] RX glitch then 0x81");
    valid_count = 0; err_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rx_valid) valid_count++;
      if (bus.rx_error) err_count++;
      rx_in = (i < 4) ? 1'b0 : 1'b1;
    end
    checkOutput("glitch_valid_count", 32'(valid_count), 32'd0);
    checkOutput("glitch_error_count", 32'(err_count), 32'd0);
    runRx(8'h81, 1'b1, 30, 1'b0, 8'h00);
    checkOutput("rx_81_valid_count", 32'(valid_count), 32'd1);
    checkOutput("rx_81_error_count", 32'(err_count), 32'd0);
    checkOutput("rx_81_data", 32'(captured), 32'h81);
    repeat (200) @(negedge clk);

    $display("[TB] simultaneous TX 0xC3 and RX 0x5A");
    runRx(8'h5A, 1'b1, 30, 1'b1, 8'hC3);
    checkOutput("simul_rx_valid_count", 32'(valid_count), 32'd1);
    checkOutput("simul_rx_data", 32'(captured), 32'h5A);
    fr = {1'b1, 8'hC3, 1'b0};
    errs = 0;
    for (int k = 0; k < 170; k++) if (txhist[k + 1] !== fr[k / 17]) errs++;
    checkOutput("simul_tx_bit_errors", 32'(errs), 32'd0);
    checkOutput("simul_tx_ends_idle", 32'(txhist[185]), 32'd1);

`ifdef UART_ECHO_EN
    repeat (200) @(negedge clk);
    $display("[TB] echo of RX 0x7E");
    runRx(8'h7E, 1'b1, 200, 1'b0, 8'h00);
    checkOutput("echo_rx_valid_count", 32'(valid_count), 32'd1);
    checkOutput("echo_rx_data", 32'(captured), 32'h7E);
    if (valid_at >= 0) begin
      checkOutput("echo_line_idle_at_valid", 32'(txhist[valid_at]), 32'd1);
      checkOutput("echo_start_next_cycle", 32'(txhist[valid_at + 1]), 32'd0);
      fr = {1'b1, 8'h7E, 1'b0};
      errs = 0;
      for (int k = 0; k < 170; k++) if (txhist[valid_at + 1 + k] !== fr[k / 17]) errs++;
      checkOutput("echo_tx_bit_errors", 32'(errs), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART: one transmitter and one receiver sharing one system clock.
- Sits between a byte-level client (handshake on `tx_ready`/`transfer`, strobe on `rx_valid`) and the serial pins.
- Baud timing derives from the system clock frequency and the baud rate parameters.
- Default configuration: 50 MHz clock, 3 Mbaud.

Parameters:
- SYSTEM_CLK_MHZ, 50, system clock frequency in MHz.
- BAUDRATE, 3_000_000, serial bit rate in bits/s.
- Derived localparam CLKS_PER_BIT = (SYSTEM_CLK_MHZ*1_000_000 + BAUDRATE/2) / BAUDRATE, i.e. rounded to nearest. Default value is 17.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- transfer  input  1  request to send `tx_data`; sampled only while `tx_ready`=1.
- tx_data  input  8  byte to transmit; captured on accept.
- tx_out  output  1  serial TX line; idles high.
- tx_ready  output  1  transmitter idle and able to accept.
- rx_in  input  1  serial RX line; asynchronous to `clk`.
- rx_valid  output  1  one-cycle strobe: a good byte is on `rx_data`.
- rx_data  output  8  last correctly received byte.
- rx_error  output  1  one-cycle strobe: framing error (stop bit read 0).

Behaviour:
- Interface: one clock, `clk`; reset is asynchronous and active-high (`reset`).
- Reset values: `tx_out`=1, `tx_ready`=1, `rx_valid`=0, `rx_error`=0, `rx_data`=0. Both FSMs go to IDLE; all counters clear.
- Reset asserted mid-frame aborts the frame immediately. `tx_out` returns high in the same cycle (async).
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit lasts CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles (170 at defaults).
- TX FSM: IDLE -> START -> DATA(8 bits) -> STOP -> IDLE.
  - In IDLE, `tx_ready`=1 and `tx_out`=1.
  - When `transfer`=1 and `tx_ready`=1 on a clock edge, `tx_data` is latched into a shift register. On that edge `tx_ready`=0 and `tx_out`=0 (start bit begins).
  - `tx_out` is registered and changes only on bit boundaries.
  - After the full stop-bit period, `tx_ready` returns to 1.
  - If `transfer` is still high when `tx_ready` returns, the next frame starts on that edge. Back-to-back frames have no extra idle cycle.
  - `transfer` while `tx_ready`=0 is ignored, not queued.
  - `tx_data` changes after accept do not affect the frame in flight.
- RX synchronisation: `rx_in` passes through a 2-flop synchroniser. All RX decisions use the synchronised signal.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a high-to-low transition of the synchronised line enters START.
  - START: wait CLKS_PER_BIT/2 cycles (8 at defaults), then sample. If the line is 1, the event is a glitch: return to IDLE with no strobe. If 0, enter DATA.
  - DATA: sample every CLKS_PER_BIT cycles at bit centre, shifting right. The first sampled bit ends in bit 0.
  - STOP: sample at the stop-bit centre.
    - Sample 1: `rx_data` is updated with the new byte and `rx_valid`=1 for exactly one cycle.
    - Sample 0: `rx_error`=1 for one cycle and `rx_data` is unchanged.
  - After the stop sample, return directly to IDLE. The next falling edge, even one half a bit later, starts a new frame.
- `rx_data` holds its value between receptions.
- RX and TX are fully independent; simultaneous operation is required.

Optional Feature:
- Macro UART_ECHO_EN.
- Defined: receiver output feeds the transmitter.
  - When `rx_valid`=1 and `tx_ready`=1 on the same edge, the TX accepts `rx_data` as if `transfer` were asserted. Echo takes priority over an external `transfer` in the same cycle.
  - If TX is busy when `rx_valid` pulses, that echo byte is dropped.
- Undefined: TX is driven only by `transfer`/`tx_data`.

Test Plan:
- Reset then idle: `reset` pulse -> `tx_out`=1, `tx_ready`=1, `rx_valid`=0, `rx_error`=0, `rx_data`=0x00.
- TX byte 0xA5 (defaults): `transfer` for 1 cycle ->
  - `tx_ready`=0 for 170 cycles;
  - `tx_out` sequence 0,1,0,1,0,0,1,0,1,1, each level for 17 cycles;
  - `tx_ready`=1 after that.
- RX byte 0x3C driven at 17 cycles/bit -> single `rx_valid` pulse with `rx_data`=0x3C, within 17+2 cycles after the stop-bit start; `rx_error` stays 0.
- RX framing error: frame 0x55 with stop bit 0 -> `rx_error` one-cycle pulse, no `rx_valid`, `rx_data` keeps its previous value.
- RX glitch: `rx_in` low for 4 cycles, then high -> no `rx_valid`/`rx_error`; a following valid frame 0x81 is received correctly.
- Back-to-back TX: hold `transfer`=1 with `tx_data` 0x01 then 0x02 -> two contiguous 170-cycle frames, no idle gap.
- With UART_ECHO_EN: send 0x7E on `rx_in` -> 0x7E appears on `tx_out` starting the cycle after `rx_valid`.
